// File: rtl/bip_control_pkg.sv
// Shared BIP encodings: field widths, opcodes, ACC/ALU source selects, sequencer states and the decoded-control bundle.
// The datapath imports the same SELA_*/SELB_* values so both sides agree on mux encodings.
package bip_control_pkg;

    localparam int NBITS_PC = 11;
    localparam int NBITS_I  = 16;
    localparam int NBITS_OP = 5;
    localparam int NBITS_O  = 11;

    localparam logic [NBITS_OP-1:0] OP_HLT  = 5'b00000;
    localparam logic [NBITS_OP-1:0] OP_STO  = 5'b00001;
    localparam logic [NBITS_OP-1:0] OP_LD   = 5'b00010;
    localparam logic [NBITS_OP-1:0] OP_LDI  = 5'b00011;
    localparam logic [NBITS_OP-1:0] OP_ADD  = 5'b00100;
    localparam logic [NBITS_OP-1:0] OP_ADDI = 5'b00101;
    localparam logic [NBITS_OP-1:0] OP_SUB  = 5'b00110;
    localparam logic [NBITS_OP-1:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SELA_MEM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    localparam logic SELB_MEM = 1'b0;
    localparam logic SELB_IMM = 1'b1;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
        logic       is_hlt;
    } ctrl_t;

    function automatic logic [NBITS_OP-1:0] opcode_of(input logic [NBITS_I-1:0] instr);
        return instr[NBITS_I-1:NBITS_O];
    endfunction

endpackage

// File: rtl/bip_control_if.sv
// Program-memory and datapath-control bundle between the BIP sequencer (master) and its environment (slave).
interface bip_control_if;
    import bip_control_pkg::*;

    logic                i_start;
    logic [NBITS_I-1:0]  i_Instruction;
    logic [NBITS_PC-1:0] o_AddrPM;
    logic [NBITS_O-1:0]  o_Operand;
    logic [1:0]          o_SelA;
    logic                o_SelB;
    logic                o_WrAcc;
    logic                o_Op;
    logic                o_WrRam;
    logic                o_RdRam;
    logic                o_halted;

    modport master (
        input  i_start, i_Instruction,
        output o_AddrPM, o_Operand, o_SelA, o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam, o_halted
    );

    modport slave (
        output i_start, i_Instruction,
        input  o_AddrPM, o_Operand, o_SelA, o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam, o_halted
    );

endinterface

// File: rtl/bip_control_decoder.sv
// Purely combinational opcode decoder; rd_ram flags opcodes whose EXEC consumes data-memory data.
// Opcodes 01000-11111 decode to an all-zero bundle (NOP).
module bip_control_decoder
    import bip_control_pkg::*;
(
    input  logic [NBITS_OP-1:0] opcode_i,
    output ctrl_t               ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (opcode_i)
            OP_HLT:  ctrl_o.is_hlt = 1'b1;
            OP_STO:  ctrl_o.wr_ram = 1'b1;
            OP_LD: begin
                ctrl_o.sel_a  = SELA_MEM;
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.rd_ram = 1'b1;
            end
            OP_LDI: begin
                ctrl_o.sel_a  = SELA_IMM;
                ctrl_o.wr_acc = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = SELB_MEM;
                ctrl_o.op     = (opcode_i == OP_SUB) ? ALU_SUB : ALU_ADD;
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.rd_ram = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = SELB_IMM;
                ctrl_o.op     = (opcode_i == OP_SUBI) ? ALU_SUB : ALU_ADD;
                ctrl_o.wr_acc = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// BIP fetch/decode/exec sequencer: owns PC and IR, retires one instruction every 3 cycles until HLT.
// All outputs are forced idle while i_reset is high so an aborted instruction never strobes.
module bip_control
    import bip_control_pkg::*;
(
    input  logic          i_clock,
    input  logic          i_reset,
    bip_control_if.master bus
);

    logic [2:0]          state_q, state_d;
    logic [NBITS_PC-1:0] pc_q, pc_d;
    logic [NBITS_I-1:0]  ir_q, ir_d;
    logic                in_decode, in_exec, live;
    logic [NBITS_OP-1:0] opcode;
    ctrl_t               ctrl;

    assign in_decode = (state_q == ST_DECODE);
    assign in_exec   = (state_q == ST_EXEC);
    assign live      = !i_reset;

    // DECODE looks ahead at the fresh instruction word so RdRam lands one cycle before EXEC.
    assign opcode = in_decode ? opcode_of(bus.i_Instruction) : opcode_of(ir_q);

    bip_control_decoder u_decoder (
        .opcode_i (opcode),
        .ctrl_o   (ctrl)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE:   if (bus.i_start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d    = bus.i_Instruction;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (ctrl.is_hlt) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d    = pc_q + NBITS_PC'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.o_AddrPM  = pc_q;
    assign bus.o_Operand = in_decode ? bus.i_Instruction[NBITS_O-1:0] : ir_q[NBITS_O-1:0];
    assign bus.o_SelA    = (in_exec && live) ? ctrl.sel_a : SELA_MEM;
    assign bus.o_SelB    = in_exec && live && ctrl.sel_b;
    assign bus.o_Op      = in_exec && live && ctrl.op;
    assign bus.o_WrAcc   = in_exec && live && ctrl.wr_acc;
    assign bus.o_WrRam   = in_exec && live && ctrl.wr_ram;
    assign bus.o_RdRam   = in_decode && live && ctrl.rd_ram;
    assign bus.o_halted  = (state_q == ST_HALT) && live;

endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: decode table, hand-written corner sequences and random programs against an instruction-level model.
module tb_bip_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] pm [0:2047];

    bip_control_if bus ();

    bip_control dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: word appears the cycle after its address.
    always @(posedge clk) bus.i_Instruction <= pm[bus.o_AddrPM];

    typedef struct {
        logic [4:0]  opc;
        logic [10:0] operand;
        logic [1:0]  sela;
        logic        selb;
        logic        op;
        logic        wracc;
        logic        wrram;
        logic        rdram;
        logic        hlt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " wracc"}, int'(bus.o_WrAcc), 0);
        chk({nm, " wrram"}, int'(bus.o_WrRam), 0);
        chk({nm, " rdram"}, int'(bus.o_RdRam), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the bench at the negedge of cycle 1 (the first FETCH).
    task automatic pulse_start();
        @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    function automatic logic [15:0] mk(input int opc, input int operand);
        logic [15:0] w;
        w = {5'(opc), 11'(operand)};
        return w;
    endfunction

    // Expected EXEC/DECODE behaviour of one opcode, from the instruction-set rules.
    function automatic logic [6:0] expect_ctrl(input int opc);
        logic alu, selb, op, wracc, wrram, rdram;
        logic [1:0] sela;
        alu   = (opc >= 4 && opc <= 7);
        selb  = alu && (opc % 2 == 1);
        op    = alu && (opc >= 6);
        sela  = alu ? 2'b10 : ((opc == 3) ? 2'b01 : 2'b00);
        wracc = (opc >= 2 && opc <= 7);
        wrram = (opc == 1);
        rdram = (opc == 2 || opc == 4 || opc == 6);
        return {sela, selb, op, wracc, wrram, rdram};
    endfunction

    // Instruction-level model: cycle n (from 1) belongs to instruction (n-1)/3, phase (n-1)%3.
    task automatic run_prog(input int ncyc, input string tag);
        int h, k, ph, opc;
        logic [6:0] e;
        h = -1;
        for (int i = 0; i <= ncyc / 3 + 1; i++) begin
            if (pm[i % 2048][15:11] == 5'd0) begin
                h = i;
                break;
            end
        end
        pulse_start();
        for (int n = 1; n <= ncyc; n++) begin
            if (n > 1) @(negedge clk);
            k  = (n - 1) / 3;
            ph = (n - 1) % 3;
            if (h >= 0 && n > 3 * h + 3) begin
                chk({tag, " halt addr"}, int'(bus.o_AddrPM), h);
                chk({tag, " halted"}, int'(bus.o_halted), 1);
                chk_quiet({tag, " halt"});
            end else begin
                opc = int'(pm[k % 2048][15:11]);
                e   = expect_ctrl(opc);
                chk({tag, " addr"}, int'(bus.o_AddrPM), k % 2048);
                chk({tag, " halted"}, int'(bus.o_halted), 0);
                chk({tag, " wracc"}, int'(bus.o_WrAcc), (ph == 2) ? int'(e[2]) : 0);
                chk({tag, " wrram"}, int'(bus.o_WrRam), (ph == 2) ? int'(e[1]) : 0);
                chk({tag, " rdram"}, int'(bus.o_RdRam), (ph == 1) ? int'(e[0]) : 0);
                if (ph != 0) chk({tag, " operand"}, int'(bus.o_Operand), int'(pm[k % 2048][10:0]));
                if (ph == 2) begin
                    chk({tag, " sela"}, int'(bus.o_SelA), int'(e[6:5]));
                    chk({tag, " selb"}, int'(bus.o_SelB), int'(e[4]));
                    chk({tag, " op"}, int'(bus.o_Op), int'(e[3]));
                end
            end
        end
    endtask

    initial begin
        bus.i_start = 1'b0;
        for (int i = 0; i < 2048; i++) pm[i] = mk(31, 0);

        vecs[0] = '{5'd0,  11'd100,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{5'd1,  11'd7,    2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{5'd2,  11'd2047, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{5'd3,  11'd5,    2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{5'd4,  11'd300,  2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{5'd5,  11'd3,    2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{5'd6,  11'd12,   2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{5'd7,  11'd1024, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{5'd8,  11'd55,   2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{5'd31, 11'd1,    2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state, then idle with start low: nothing may execute.
        do_reset();
        chk("reset addr", int'(bus.o_AddrPM), 0);
        chk("reset halted", int'(bus.o_halted), 0);
        chk("reset sela", int'(bus.o_SelA), 0);
        chk("reset selb", int'(bus.o_SelB), 0);
        chk("reset op", int'(bus.o_Op), 0);
        chk_quiet("reset");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("idle addr", int'(bus.o_AddrPM), 0);
            chk_quiet("idle");
        end

        // Decode table, one instruction at PC=0 each.
        foreach (vecs[v]) begin
            do_reset();
            pm[0] = mk(int'(vecs[v].opc), int'(vecs[v].operand));
            pm[1] = mk(31, 0);
            pulse_start();
            @(negedge clk);
            chk("tbl decode rdram", int'(bus.o_RdRam), int'(vecs[v].rdram));
            chk("tbl decode operand", int'(bus.o_Operand), int'(vecs[v].operand));
            chk("tbl decode wracc", int'(bus.o_WrAcc), 0);
            @(negedge clk);
            chk("tbl exec sela", int'(bus.o_SelA), int'(vecs[v].sela));
            chk("tbl exec selb", int'(bus.o_SelB), int'(vecs[v].selb));
            chk("tbl exec op", int'(bus.o_Op), int'(vecs[v].op));
            chk("tbl exec wracc", int'(bus.o_WrAcc), int'(vecs[v].wracc));
            chk("tbl exec wrram", int'(bus.o_WrRam), int'(vecs[v].wrram));
            chk("tbl exec rdram", int'(bus.o_RdRam), 0);
            chk("tbl exec operand", int'(bus.o_Operand), int'(vecs[v].operand));
            @(negedge clk);
            chk("tbl next halted", int'(bus.o_halted), int'(vecs[v].hlt));
            chk("tbl next addr", int'(bus.o_AddrPM), vecs[v].hlt ? 0 : 1);
        end

        // LDI 5; ADDI 3; STO 7; HLT, cycle-exact pulse positions.
        do_reset();
        pm[0] = mk(3, 5);
        pm[1] = mk(5, 3);
        pm[2] = mk(1, 7);
        pm[3] = mk(0, 0);
        pulse_start();
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            chk("prog wracc", int'(bus.o_WrAcc), (n == 3 || n == 6) ? 1 : 0);
            chk("prog wrram", int'(bus.o_WrRam), (n == 9) ? 1 : 0);
            if (n == 9) chk("prog sto operand", int'(bus.o_Operand), 7);
            chk("prog halted", int'(bus.o_halted), (n >= 13) ? 1 : 0);
            if (n >= 12) chk("prog halt pc", int'(bus.o_AddrPM), 3);
        end

        // i_start is ignored while halted.
        bus.i_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("halt start halted", int'(bus.o_halted), 1);
            chk("halt start pc", int'(bus.o_AddrPM), 3);
            chk_quiet("halt start");
        end
        bus.i_start = 1'b0;
        do_reset();
        chk("halt reset halted", int'(bus.o_halted), 0);
        run_prog(12, "resume");

        // Reset landing in the EXEC cycle of an ADD at PC=1.
        do_reset();
        pm[0] = mk(31, 0);
        pm[1] = mk(4, 9);
        pulse_start();
        repeat (5) @(negedge clk);
        chk("abort pre wracc", int'(bus.o_WrAcc), 1);
        rst = 1'b1;
        #1;
        chk("abort exec wracc", int'(bus.o_WrAcc), 0);
        chk("abort exec sela", int'(bus.o_SelA), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort after addr", int'(bus.o_AddrPM), 0);
        chk("abort after halted", int'(bus.o_halted), 0);
        chk_quiet("abort after");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort idle addr", int'(bus.o_AddrPM), 0);
            chk_quiet("abort idle");
        end

        // PC wrap: all NOPs across address 2047.
        do_reset();
        for (int i = 0; i < 2048; i++) pm[i] = mk($urandom_range(8, 31), $urandom_range(0, 2047));
        run_prog(3 * 2049 + 2, "wrap");

        // Random programs with occasional HLT.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 2048; i++)
                pm[i] = mk(($urandom_range(0, 29) == 0) ? 0 : $urandom_range(1, 31), $urandom_range(0, 2047));
            run_prog(3 * 80, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
